// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target predictor.
package bp_pkg;

  typedef enum logic [1:0] {
    BK_NONE = 2'd0,
    BK_COND = 2'd1,
    BK_JUMP = 2'd2
  } branch_kind_t;

  // Weakly-taken counter value (MSB set, rest clear) for counters up to 4 bits wide.
  function automatic logic [3:0] ctr_weak_taken(input int unsigned ctr_bits);
    return 4'd1 << (ctr_bits - 32'd1);
  endfunction

endpackage

// File: rtl/branch_target_predictor_sat_counter_next.sv
// Combinational saturating increment/decrement for the direction counter.
module sat_counter_next #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] ctr,
  input  logic             up,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] CTR_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CTR_MIN = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CTR_ONE = WIDTH'(1'b1);

  // Step toward the requested direction, holding at either rail.
  always_comb begin
    nxt = ctr;
    if (up) begin
      if (ctr != CTR_MAX) nxt = ctr + CTR_ONE;
      else                nxt = ctr;
    end else begin
      if (ctr != CTR_MIN) nxt = ctr - CTR_ONE;
      else                nxt = ctr;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped tagged BTB with per-entry direction counters, combinational
// fetch-side prediction and resolution-side mispredict detection and stats.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int PC_SIZE    = 12,
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int STAT_BITS  = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [PC_SIZE-1:0]   lookup_pc,
  input  logic [PC_SIZE-1:0]   lookup_next_pc,
  output logic                 predict_hit,
  output logic                 predict_taken,
  output logic [PC_SIZE-1:0]   predict_pc,
  input  logic                 upd_valid,
  input  logic [1:0]           upd_kind,
  input  logic [PC_SIZE-1:0]   upd_pc,
  input  logic [PC_SIZE-1:0]   upd_next_pc,
  input  logic                 upd_taken,
  input  logic [PC_SIZE-1:0]   upd_target,
  input  logic [PC_SIZE-1:0]   upd_pred_pc,
  output logic                 mispredict,
  output logic [PC_SIZE-1:0]   redirect_pc,
  input  logic                 stats_clear,
  output logic [STAT_BITS-1:0] branch_count,
  output logic [STAT_BITS-1:0] mispredict_count
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = PC_SIZE - INDEX_BITS;
  localparam logic [3:0]          WEAK_FULL = ctr_weak_taken(CTR_BITS);
  localparam logic [CTR_BITS-1:0] CTR_WEAK  = WEAK_FULL[CTR_BITS-1:0];
  localparam logic [STAT_BITS-1:0] STAT_MAX = {STAT_BITS{1'b1}};
  localparam logic [STAT_BITS-1:0] STAT_ONE = STAT_BITS'(1'b1);

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic                is_jump;
    logic [PC_SIZE-1:0]  target;
    logic [CTR_BITS-1:0] ctr;
  } btb_entry_t;

  localparam btb_entry_t ENTRY_RESET = '{1'b0, {TAG_BITS{1'b0}}, 1'b0, {PC_SIZE{1'b0}}, CTR_WEAK};

  btb_entry_t                table_r [ENTRIES];
  logic [INDEX_BITS-1:0]     lk_idx_s;
  logic [TAG_BITS-1:0]       lk_tag_s;
  logic [INDEX_BITS-1:0]     up_idx_s;
  logic [TAG_BITS-1:0]       up_tag_s;
  btb_entry_t                up_entry_s;
  logic                      up_hit_s;
  branch_kind_t              kind_s;
  logic                      taken_eff_s;
  logic [PC_SIZE-1:0]        actual_pc_s;
  logic [CTR_BITS-1:0]       ctr_next_s;
  logic                      wr_en_s;
  btb_entry_t                wr_entry_s;
  logic [STAT_BITS-1:0]      branch_count_r;
  logic [STAT_BITS-1:0]      mispredict_count_r;

  assign lk_idx_s   = lookup_pc[INDEX_BITS-1:0];
  assign lk_tag_s   = lookup_pc[PC_SIZE-1:INDEX_BITS];
  assign up_idx_s   = upd_pc[INDEX_BITS-1:0];
  assign up_tag_s   = upd_pc[PC_SIZE-1:INDEX_BITS];
  assign up_entry_s = table_r[up_idx_s];
  assign up_hit_s   = up_entry_s.valid && (up_entry_s.tag == up_tag_s);

  // Fetch-side prediction reads the pre-edge table contents (no bypass).
  always_comb begin
    predict_hit   = table_r[lk_idx_s].valid && (table_r[lk_idx_s].tag == lk_tag_s);
    predict_taken = predict_hit && (table_r[lk_idx_s].is_jump || table_r[lk_idx_s].ctr[CTR_BITS-1]);
    if (predict_taken) predict_pc = table_r[lk_idx_s].target;
    else               predict_pc = lookup_next_pc;
  end

  // Decode the resolved kind; the unused encoding behaves as NONE.
  always_comb begin
    kind_s = BK_NONE;
    case (upd_kind)
      2'd1:    kind_s = BK_COND;
      2'd2:    kind_s = BK_JUMP;
      default: kind_s = BK_NONE;
    endcase
  end

  // Resolution: the true next PC and whether fetch went the wrong way.
  always_comb begin
    if (kind_s == BK_JUMP) taken_eff_s = 1'b1;
    else                   taken_eff_s = upd_taken;
    if ((kind_s != BK_NONE) && taken_eff_s) actual_pc_s = upd_target;
    else                                    actual_pc_s = upd_next_pc;
    mispredict  = upd_valid && (actual_pc_s != upd_pred_pc);
    redirect_pc = actual_pc_s;
  end

  sat_counter_next #(.WIDTH(CTR_BITS)) u_ctr_next (
    .ctr (up_entry_s.ctr),
    .up  (upd_taken),
    .nxt (ctr_next_s)
  );

  // Training: decide whether and what to write into the indexed entry.
  always_comb begin
    wr_en_s    = 1'b0;
    wr_entry_s = up_entry_s;
    if (upd_valid) begin
      case (kind_s)
        BK_COND: begin
          if (up_hit_s) begin
            wr_en_s            = 1'b1;
            wr_entry_s.ctr     = ctr_next_s;
            wr_entry_s.is_jump = 1'b0;
            if (upd_taken) wr_entry_s.target = upd_target;
            else           wr_entry_s.target = up_entry_s.target;
          end else if (upd_taken) begin
            wr_en_s    = 1'b1;
            wr_entry_s = '{1'b1, up_tag_s, 1'b0, upd_target, CTR_WEAK};
          end else begin
            wr_en_s = 1'b0;
          end
        end
        BK_JUMP: begin
          wr_en_s            = 1'b1;
          wr_entry_s.valid   = 1'b1;
          wr_entry_s.tag     = up_tag_s;
          wr_entry_s.is_jump = 1'b1;
          wr_entry_s.target  = upd_target;
          if (up_hit_s) wr_entry_s.ctr = up_entry_s.ctr;
          else          wr_entry_s.ctr = CTR_WEAK;
        end
        BK_NONE: begin
          // A non-branch that hits means the entry is a stale alias.
          if (up_hit_s) begin
            wr_en_s          = 1'b1;
            wr_entry_s.valid = 1'b0;
          end else begin
            wr_en_s = 1'b0;
          end
        end
        default: wr_en_s = 1'b0;
      endcase
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Table storage; reset clears every entry, so these must be flops.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < ENTRIES; i++) table_r[i] <= ENTRY_RESET;
    end else if (wr_en_s) begin
      table_r[up_idx_s] <= wr_entry_s;
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      branch_count_r     <= {STAT_BITS{1'b0}};
      mispredict_count_r <= {STAT_BITS{1'b0}};
    end else if (stats_clear) begin
      branch_count_r     <= {STAT_BITS{1'b0}};
      mispredict_count_r <= {STAT_BITS{1'b0}};
    end else begin
      if (upd_valid && (kind_s != BK_NONE) && (branch_count_r != STAT_MAX))
        branch_count_r <= branch_count_r + STAT_ONE;
      if (mispredict && (mispredict_count_r != STAT_MAX))
        mispredict_count_r <= mispredict_count_r + STAT_ONE;
    end
  end

  assign branch_count     = branch_count_r;
  assign mispredict_count = mispredict_count_r;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_branch_target_predictor;

  localparam int PC_SIZE    = 12;
  localparam int INDEX_BITS = 6;
  localparam int CTR_BITS   = 2;
  localparam int STAT_BITS  = 4;
  localparam int NENT  = 1 << INDEX_BITS;
  localparam int PCMSK = (1 << PC_SIZE) - 1;
  localparam int CMAX  = (1 << CTR_BITS) - 1;
  localparam int WEAK  = 1 << (CTR_BITS - 1);
  localparam int SMAX  = (1 << STAT_BITS) - 1;

  logic                 CLK, RESET_N;
  logic [PC_SIZE-1:0]   lookup_pc, lookup_next_pc, predict_pc;
  logic                 predict_hit, predict_taken;
  logic                 upd_valid, upd_taken, mispredict, stats_clear;
  logic [1:0]           upd_kind;
  logic [PC_SIZE-1:0]   upd_pc, upd_next_pc, upd_target, upd_pred_pc, redirect_pc;
  logic [STAT_BITS-1:0] branch_count, mispredict_count;

  branch_target_predictor #(
    .PC_SIZE(PC_SIZE), .INDEX_BITS(INDEX_BITS), .CTR_BITS(CTR_BITS), .STAT_BITS(STAT_BITS)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .lookup_pc(lookup_pc), .lookup_next_pc(lookup_next_pc),
    .predict_hit(predict_hit), .predict_taken(predict_taken), .predict_pc(predict_pc),
    .upd_valid(upd_valid), .upd_kind(upd_kind), .upd_pc(upd_pc), .upd_next_pc(upd_next_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_pc(upd_pred_pc),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stats_clear(stats_clear), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int hit; int taken; int pc; int misp; int redir; int bc; int mc;
  } exp_t;
  exp_t exp_q[$];

  int n_vec  = 0;
  int n_fail = 0;

  // Behavioural BTB contents, kept as plain integers per index.
  int m_valid[NENT], m_tag[NENT], m_jump[NENT], m_target[NENT], m_ctr[NENT];
  int m_bc, m_mc;

  function automatic void model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_jump[i] = 0; m_target[i] = 0; m_ctr[i] = WEAK;
    end
    m_bc = 0; m_mc = 0;
  endfunction

  function automatic int m_hit(int pc);
    return (m_valid[pc % NENT] != 0 && m_tag[pc % NENT] == pc / NENT) ? 1 : 0;
  endfunction

  function automatic int m_taken(int pc);
    int i = pc % NENT;
    return (m_hit(pc) != 0 && (m_jump[i] != 0 || m_ctr[i] >= WEAK)) ? 1 : 0;
  endfunction

  function automatic int m_pred(int pc);
    return (m_taken(pc) != 0) ? m_target[pc % NENT] : ((pc + 1) & PCMSK);
  endfunction

  function automatic int m_actual(int kind, int pc, int taken, int tgt);
    int taken_eff = (kind == 2) ? 1 : taken;
    return ((kind == 1 || kind == 2) && taken_eff != 0) ? tgt : ((pc + 1) & PCMSK);
  endfunction

  function automatic void model_update(int uv, int kind, int pc, int taken, int tgt, int sclr, int misp);
    int i = pc % NENT;
    int t = pc / NENT;
    int h = m_hit(pc);
    if (sclr != 0) begin
      m_bc = 0; m_mc = 0;
    end else begin
      if (uv != 0 && (kind == 1 || kind == 2) && m_bc < SMAX) m_bc++;
      if (misp != 0 && m_mc < SMAX) m_mc++;
    end
    if (uv == 0) return;
    if (kind == 1) begin
      if (h != 0) begin
        m_ctr[i] = (taken != 0) ? ((m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX)
                                : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (taken != 0) m_target[i] = tgt;
        m_jump[i] = 0;
      end else if (taken != 0) begin
        m_valid[i] = 1; m_tag[i] = t; m_jump[i] = 0; m_target[i] = tgt; m_ctr[i] = WEAK;
      end
    end else if (kind == 2) begin
      if (h == 0) m_ctr[i] = WEAK;
      m_valid[i] = 1; m_tag[i] = t; m_jump[i] = 1; m_target[i] = tgt;
    end else if (h != 0) begin
      m_valid[i] = 0;
    end
  endfunction

  function automatic exp_t make_exp(int lpc, int uv, int kind, int upc, int taken, int tgt, int upred);
    exp_t e;
    e.hit   = m_hit(lpc);
    e.taken = m_taken(lpc);
    e.pc    = m_pred(lpc);
    e.redir = m_actual(kind, upc, taken, tgt);
    e.misp  = (uv != 0 && e.redir != upred) ? 1 : 0;
    e.bc    = m_bc;
    e.mc    = m_mc;
    return e;
  endfunction

  // upred < 0 means "carry the model's own fetch prediction for upd_pc".
  task automatic drive(int lpc, int uv, int kind, int upc, int taken, int tgt, int upred, int sclr);
    exp_t e;
    int pred = (upred < 0) ? m_pred(upc) : upred;
    lookup_pc      = PC_SIZE'(lpc);
    lookup_next_pc = PC_SIZE'((lpc + 1) & PCMSK);
    upd_valid      = uv[0];
    upd_kind       = 2'(kind);
    upd_pc         = PC_SIZE'(upc);
    upd_next_pc    = PC_SIZE'((upc + 1) & PCMSK);
    upd_taken      = taken[0];
    upd_target     = PC_SIZE'(tgt);
    upd_pred_pc    = PC_SIZE'(pred);
    stats_clear    = sclr[0];
    e = make_exp(lpc, uv, kind, upc, taken, tgt, pred);
    exp_q.push_back(e);
    @(posedge CLK);
    model_update(uv, kind, upc, taken, tgt, sclr, e.misp);
    #1;
  endtask

  task automatic look(int lpc);
    drive(lpc, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Async reset landing on a cycle with a valid update: the write must be lost.
  task automatic reset_mid(int lpc, int upc, int tgt);
    exp_t e;
    lookup_pc = PC_SIZE'(lpc);  lookup_next_pc = PC_SIZE'((lpc + 1) & PCMSK);
    upd_valid = 1'b1;  upd_kind = 2'd1;  upd_pc = PC_SIZE'(upc);
    upd_next_pc = PC_SIZE'((upc + 1) & PCMSK);  upd_taken = 1'b1;
    upd_target = PC_SIZE'(tgt);  upd_pred_pc = PC_SIZE'((upc + 1) & PCMSK);  stats_clear = 1'b0;
    RESET_N = 1'b0;
    model_reset();
    #1;
    e = make_exp(lpc, 1, 1, upc, 1, tgt, (upc + 1) & PCMSK);
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  task automatic check(string name, logic [31:0] act, int expv);
    if (act !== 32'(expv)) begin
      n_fail++;
      $display("FAIL %s vector %0d: got 0x%0h, expected 0x%0h", name, n_vec, act, expv);
    end
  endtask

  // Monitor: compare the DUT against the oldest pending expectation mid-cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      check("predict_hit",      32'(predict_hit),      e.hit);
      check("predict_taken",    32'(predict_taken),    e.taken);
      check("predict_pc",       32'(predict_pc),       e.pc);
      check("mispredict",       32'(mispredict),       e.misp);
      if (e.misp != 0) check("redirect_pc", 32'(redirect_pc), e.redir);
      check("branch_count",     32'(branch_count),     e.bc);
      check("mispredict_count", 32'(mispredict_count), e.mc);
    end
  end

  int pool[8] = '{12'h010, 12'h050, 12'h450, 12'h123, 12'h163, 12'h7C0, 12'hFFF, 12'h000};

  initial begin
    RESET_N = 1'b0;
    lookup_pc = '0; lookup_next_pc = '0; upd_valid = 1'b0; upd_kind = 2'd0; upd_pc = '0;
    upd_next_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_pred_pc = '0; stats_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;

    look(12'h010);
    drive(12'h010, 1, 1, 12'h010, 1, 12'h080, 12'h011, 0);
    look(12'h010);
    drive(12'h010, 1, 1, 12'h010, 0, 12'h080, -1, 0);
    drive(12'h010, 1, 1, 12'h010, 0, 12'h080, -1, 0);
    for (int k = 0; k < 6; k++) drive(12'h010, 1, 1, 12'h010, 1, 12'h080, -1, 0);
    drive(12'h010, 1, 1, 12'h010, 0, 12'h080, -1, 0);
    look(12'h010);

    drive(12'h450, 1, 2, 12'h050, 1, 12'h200, -1, 0);
    look(12'h450);
    drive(12'h050, 1, 1, 12'h450, 1, 12'h300, -1, 0);
    look(12'h050);
    drive(12'h450, 1, 0, 12'h450, 0, 12'h000, -1, 0);
    look(12'h450);

    drive(12'h123, 1, 1, 12'h123, 1, 12'h3C0, -1, 0);
    look(12'h123);
    drive(12'h123, 1, 3, 12'h123, 1, 12'h3C0, -1, 0);
    look(12'h123);

    for (int k = 0; k < 20; k++) drive(12'h7C0, 1, 1 + (k % 2), 12'h7C0, 1, 12'h400, -1, 0);
    drive(12'h7C0, 1, 1, 12'h7C0, 0, 12'h400, 12'h555, 1);
    look(12'h7C0);
    reset_mid(12'h7C0, 12'h7C0, 12'h444);
    look(12'h7C0);
    look(12'h123);

    for (int k = 0; k < 400; k++) begin
      int lpc  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, PCMSK)) : pool[$urandom_range(0, 7)];
      int upc  = pool[$urandom_range(0, 7)];
      int pred = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, PCMSK)) : -1;
      drive(lpc, int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), upc,
            int'($urandom_range(0, 1)), int'($urandom_range(0, PCMSK)), pred,
            int'($urandom_range(0, 49) == 0));
    end

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
